// File: rtl/reg_busy_scoreboard.sv
// Per-register pending-write scoreboard: counts in-flight writes per register
// and reports operand readiness and issue permission to the hazard logic.
module reg_busy_scoreboard #(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned MAX_PEND = 3,
  parameter int unsigned CW       = 3,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_rd,
  output logic             issue_ok,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_rd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic             rs1_ready,
  output logic             rs2_ready,
  output logic [NREGS-1:0] busy_vec,
  output logic [AW+CW-1:0] pend_total,
  output logic             err_underflow
);

  logic [CW-1:0]    cnt_q [1:NREGS-1];
  logic [CW-1:0]    cnt_d [1:NREGS-1];
  logic [CW-1:0]    cnt_v [NREGS];
  logic [AW+CW-1:0] pend_total_q;
  logic [AW+CW-1:0] pend_total_d;
  logic             err_underflow_q;
  logic             err_underflow_d;

  logic iss_acc;
  logic wb_hit;
  logic wb_under;

  // Register 0 has no counter; expose it as a permanent zero.
  always_comb begin
    cnt_v[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      cnt_v[i] = cnt_q[i];
    end
  end

  always_comb begin
    issue_ok = (issue_rd == '0) ||
               (cnt_v[issue_rd] < CW'(MAX_PEND));
    iss_acc  = issue_en && issue_ok && (issue_rd != '0);
    wb_hit   = wb_en && (wb_rd != '0) && (cnt_v[wb_rd] != '0);
    wb_under = wb_en && (wb_rd != '0) && (cnt_v[wb_rd] == '0);
  end

  function automatic logic src_ready(input logic [AW-1:0] rs,
                                     input logic [CW-1:0] cnt);
    logic rdy;
    rdy = (rs == '0) || (cnt == '0);
    if (BYPASS && cnt == CW'(1) && wb_en && wb_rd == rs) begin
      rdy = 1'b1;
    end
    return rdy;
  endfunction

  always_comb begin
    rs1_ready = src_ready(rs1, cnt_v[rs1]);
    rs2_ready = src_ready(rs2, cnt_v[rs2]);
  end

  // Issue and retire on the same register cancel out.
  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (iss_acc && issue_rd == AW'(i)) begin
        cnt_d[i] = cnt_d[i] + CW'(1);
      end
      if (wb_hit && wb_rd == AW'(i)) begin
        cnt_d[i] = cnt_d[i] - CW'(1);
      end
    end
    pend_total_d = pend_total_q;
    if (iss_acc && !wb_hit) begin
      pend_total_d = pend_total_q + (AW+CW)'(1);
    end else if (wb_hit && !iss_acc) begin
      pend_total_d = pend_total_q - (AW+CW)'(1);
    end
    err_underflow_d = err_underflow_q | wb_under;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 1; i < NREGS; i++) begin
        cnt_q[i] <= '0;
      end
      pend_total_q    <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pend_total_q    <= pend_total_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NREGS; i++) begin
      busy_vec[i] = (cnt_q[i] != '0);
    end
  end

  assign pend_total    = pend_total_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_reg_busy_scoreboard.sv
// Directed bench for reg_busy_scoreboard with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are checked mid-cycle.
module tb_reg_busy_scoreboard;

  logic        clk = 1'b0;
  logic        clr;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        issue_ok;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_ready;
  logic        rs2_ready;
  logic [31:0] busy_vec;
  logic [7:0]  pend_total;
  logic        err_underflow;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_busy_scoreboard dut (
    .clk           (clk),
    .clr           (clr),
    .issue_en      (issue_en),
    .issue_rd      (issue_rd),
    .issue_ok      (issue_ok),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_ready     (rs1_ready),
    .rs2_ready     (rs2_ready),
    .busy_vec      (busy_vec),
    .pend_total    (pend_total),
    .err_underflow (err_underflow)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en = 1'b0;
    wb_en    = 1'b0;
    issue_rd = '0;
    wb_rd    = '0;
  endtask

  initial begin
    clr = 1'b1;
    idle();
    rs1 = '0;
    rs2 = '0;

    // reset with a pending issue request held high
    issue_en = 1'b1;
    issue_rd = 5'd5;
    tick();
    tick();
    clr = 1'b0;
    idle();
    rs1 = 5'd5;
    #1;
    check("rst_busy", busy_vec, 32'h0);
    check("rst_pend", 32'(pend_total), 32'd0);
    check("rst_err", 32'(err_underflow), 32'd0);
    check("rst_rs1", 32'(rs1_ready), 32'd1);
    check("rst_rs2", 32'(rs2_ready), 32'd1);
    issue_rd = 5'd5;
    #1;
    check("rst_ok", 32'(issue_ok), 32'd1);

    // issue r7, then retire with bypass
    issue_en = 1'b1;
    issue_rd = 5'd7;
    tick();
    idle();
    rs1 = 5'd7;
    rs2 = 5'd7;
    #1;
    check("r7_rs1_busy", 32'(rs1_ready), 32'd0);
    check("r7_busy", busy_vec, 32'h80);
    check("r7_pend", 32'(pend_total), 32'd1);
    wb_en = 1'b1;
    wb_rd = 5'd7;
    #1;
    check("r7_bypass1", 32'(rs1_ready), 32'd1);
    check("r7_bypass2", 32'(rs2_ready), 32'd1);
    check("r7_busy_wb", busy_vec, 32'h80);
    tick();
    idle();
    #1;
    check("r7_busy_clr", busy_vec, 32'h0);
    check("r7_pend0", 32'(pend_total), 32'd0);

    // saturate r3
    issue_en = 1'b1;
    issue_rd = 5'd3;
    #1;
    check("r3_ok0", 32'(issue_ok), 32'd1);
    tick();
    tick();
    #1;
    check("r3_ok2", 32'(issue_ok), 32'd1);
    tick();
    #1;
    check("r3_ok_sat", 32'(issue_ok), 32'd0);
    check("r3_pend3", 32'(pend_total), 32'd3);
    tick();
    idle();
    #1;
    check("r3_drop_pend", 32'(pend_total), 32'd3);
    check("r3_busy", busy_vec, 32'h8);
    issue_rd = 5'd3;
    rs1 = 5'd3;
    wb_en = 1'b1;
    wb_rd = 5'd3;
    #1;
    check("r3_nobyp_cnt3", 32'(rs1_ready), 32'd0);
    tick();
    #1;
    check("r3_ok_after_wb", 32'(issue_ok), 32'd1);
    check("r3_pend2", 32'(pend_total), 32'd2);
    check("r3_nobyp_cnt2", 32'(rs1_ready), 32'd0);
    tick();
    #1;
    check("r3_byp_cnt1", 32'(rs1_ready), 32'd1);
    tick();
    idle();
    #1;
    check("r3_pend0", 32'(pend_total), 32'd0);
    check("r3_busy0", busy_vec, 32'h0);
    check("r3_err0", 32'(err_underflow), 32'd0);

    // simultaneous issue and writeback
    issue_en = 1'b1;
    issue_rd = 5'd9;
    tick();
    wb_en = 1'b1;
    wb_rd = 5'd9;
    tick();
    #1;
    check("r9_same_pend", 32'(pend_total), 32'd1);
    check("r9_same_busy", busy_vec, 32'h200);
    issue_rd = 5'd4;
    tick();
    idle();
    #1;
    check("r4r9_busy", busy_vec, 32'h10);
    check("r4r9_pend", 32'(pend_total), 32'd1);
    wb_en = 1'b1;
    wb_rd = 5'd4;
    tick();
    idle();
    #1;
    check("r4_pend0", 32'(pend_total), 32'd0);

    // register 0 is never tracked
    issue_en = 1'b1;
    wb_en = 1'b1;
    rs1 = '0;
    #1;
    check("r0_ok", 32'(issue_ok), 32'd1);
    check("r0_rs1", 32'(rs1_ready), 32'd1);
    tick();
    idle();
    #1;
    check("r0_busy", busy_vec, 32'h0);
    check("r0_pend", 32'(pend_total), 32'd0);
    check("r0_err", 32'(err_underflow), 32'd0);

    // underflow is sticky
    wb_en = 1'b1;
    wb_rd = 5'd12;
    tick();
    idle();
    #1;
    check("uf_set", 32'(err_underflow), 32'd1);
    check("uf_pend", 32'(pend_total), 32'd0);
    tick();
    #1;
    check("uf_sticky", 32'(err_underflow), 32'd1);

    // clear mid-flight
    issue_en = 1'b1;
    issue_rd = 5'd2;
    tick();
    tick();
    issue_rd = 5'd8;
    tick();
    idle();
    #1;
    check("mid_busy", busy_vec, 32'h104);
    check("mid_pend", 32'(pend_total), 32'd3);
    clr = 1'b1;
    issue_en = 1'b1;
    issue_rd = 5'd6;
    tick();
    clr = 1'b0;
    idle();
    #1;
    check("mid_clr_busy", busy_vec, 32'h0);
    check("mid_clr_pend", 32'(pend_total), 32'd0);
    check("mid_clr_err", 32'(err_underflow), 32'd0);
    wb_en = 1'b1;
    wb_rd = 5'd2;
    tick();
    idle();
    #1;
    check("mid_wb_err", 32'(err_underflow), 32'd1);
    check("mid_wb_pend", 32'(pend_total), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
